// File: rtl/dmi_req_engine_pkg.sv
// Shared DM encodings and engine state type for the DMI request engine.
package dmi_req_engine_pkg;

  typedef enum logic [1:0] {
    DmOpNop   = 2'd0,
    DmOpRead  = 2'd1,
    DmOpWrite = 2'd2,
    DmOpRsvd  = 2'd3
  } dm_op_e;

  typedef enum logic [1:0] {
    DmRespOk     = 2'd0,
    DmRespRsvd   = 2'd1,
    DmRespFailed = 2'd2,
    DmRespBusy   = 2'd3
  } dm_resp_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StRsp  = 2'd3
  } engine_state_e;

  // Only reads and writes touch the DM; nop and reserved are answered locally.
  function automatic logic isDmAccess(input logic [1:0] op);
    return (op == DmOpRead) || (op == DmOpWrite);
  endfunction

endpackage

// File: rtl/dmi_req_engine_fifo.sv
// Command FIFO: circular buffer with occupancy count and a flush that empties it.
module dmi_req_fifo #(
  parameter int Width = 41,
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wrPtr;
  logic [PtrW-1:0]  r_rdPtr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CountFull);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rdPtr];

  // A push while full is ignored so stored entries are never overwritten.
  assign w_push = push_i && !full_o && !flush_i;
  assign w_pop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= data_i;
  end

endmodule

// File: rtl/dmi_req_engine.sv
// DMI request engine: queues debugger commands, issues them to the DM one at a
// time, and returns one response per command with a sticky error status.
module dmi_req_engine
  import dmi_req_engine_pkg::*;
#(
  parameter int AddrWidth   = 7,
  parameter int Depth       = 4,
  parameter int StallOnFull = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [31:0]            cmd_data_i,
  input  logic [1:0]             cmd_op_i,
  output logic                   cmd_ready_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_data_o,
  output logic [1:0]             rsp_status_o,
  output logic [AddrWidth+33:0]  dmi_req_o,
  output logic                   dmi_req_valid_o,
  input  logic                   dmi_req_ready_i,
  input  logic [33:0]            dmi_resp_i,
  input  logic                   dmi_resp_valid_i,
  output logic                   dmi_resp_ready_o,
  input  logic                   dmi_reset_i,
  input  logic                   dmi_hard_reset_i,
  output logic [1:0]             error_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   idle_o
);

  localparam int ReqWidth = AddrWidth + 34;

  engine_state_e          r_state;
  engine_state_e          w_stateNext;
  logic [AddrWidth-1:0]   r_txnAddr;
  logic [1:0]             r_txnOp;
  logic [31:0]            r_txnData;
  logic [31:0]            r_rspData;
  logic [1:0]             r_rspStatus;
  logic [1:0]             r_error;
  logic                   r_discard;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_overflow;
  logic                   w_respFire;
  logic                   w_dmErr;
  logic [ReqWidth-1:0]    w_head;
  logic [1:0]             w_headOp;

  assign cmd_ready_o = (StallOnFull != 0) ? !w_full : 1'b1;
  assign w_push      = cmd_valid_i && cmd_ready_o;
  assign w_overflow  = (StallOnFull == 0) && cmd_valid_i && w_full;
  assign w_headOp    = w_head[33:32];
  assign w_respFire  = (r_state == StWait) && dmi_resp_valid_i;
  assign w_dmErr     = w_respFire && dmi_resp_i[1];

  dmi_req_fifo #(
    .Width (ReqWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (dmi_hard_reset_i),
    .push_i  (w_push),
    .data_i  ({cmd_addr_i, cmd_op_i, cmd_data_i}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_stateNext;
  end

  // Next-state and handshake outputs; skipped commands bypass the DM entirely.
  always_comb begin
    w_stateNext      = r_state;
    w_pop            = 1'b0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    rsp_valid_o      = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty && !dmi_hard_reset_i) begin
          w_pop = 1'b1;
          if (!isDmAccess(w_headOp) || (r_error != 2'd0)) w_stateNext = StRsp;
          else                                            w_stateNext = StReq;
        end
      end
      StReq: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) w_stateNext = StWait;
      end
      StWait: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          w_stateNext = (r_discard || dmi_hard_reset_i) ? StIdle : StRsp;
        end
      end
      StRsp: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i || dmi_hard_reset_i) w_stateNext = StIdle;
      end
      default: w_stateNext = StIdle;
    endcase
  end

  // Transaction and response registers, plus the flag that drops a flushed response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_txnAddr   <= '0;
      r_txnOp     <= '0;
      r_txnData   <= '0;
      r_rspData   <= '0;
      r_rspStatus <= '0;
      r_discard   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_txnAddr <= w_head[ReqWidth-1:34];
        r_txnOp   <= w_headOp;
        r_txnData <= w_head[31:0];
        r_rspData <= '0;
        if (r_error != 2'd0) r_rspStatus <= r_error;
        else                 r_rspStatus <= DmRespOk;
      end
      if (w_respFire) begin
        r_rspStatus <= dmi_resp_i[1:0];
        r_rspData   <= (r_txnOp == DmOpRead) ? dmi_resp_i[33:2] : r_txnData;
        r_discard   <= 1'b0;
      end else if (dmi_hard_reset_i && ((r_state == StReq) || (r_state == StWait))) begin
        r_discard <= 1'b1;
      end
    end
  end

  // Sticky error: the first DM failure or overflow is kept until cleared, and a clear always wins.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || dmi_reset_i) begin
      r_error <= 2'd0;
    end else if (r_error == 2'd0) begin
      if (w_dmErr)         r_error <= dmi_resp_i[1:0];
      else if (w_overflow) r_error <= DmRespBusy;
    end
  end

  assign dmi_req_o    = {r_txnAddr, r_txnOp, r_txnData};
  assign rsp_data_o   = r_rspData;
  assign rsp_status_o = r_rspStatus;
  assign error_o      = r_error;
  assign idle_o       = (r_state == StIdle) && w_empty;

endmodule

// File: tb/tb_dmi_req_engine.sv
// Directed bench for dmi_req_engine: a stalling instance and a dropping instance
// share stimulus; a DM model and a response scoreboard follow the selected one.
module tb_dmi_req_engine;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  status;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic [6:0]  cmdAddr;
  logic [31:0] cmdData;
  logic [1:0]  cmdOp;
  logic        rspReady;
  logic        dmReqReady;
  logic [33:0] dmResp;
  logic        dmRespValid;
  logic        dmiReset;
  logic        dmiHardReset;

  logic        cmdReadyA,  cmdReadyB;
  logic        rspValidA,  rspValidB;
  logic [31:0] rspDataA,   rspDataB;
  logic [1:0]  rspStatusA, rspStatusB;
  logic [40:0] reqA,       reqB;
  logic        reqValidA,  reqValidB;
  logic        respReadyA, respReadyB;
  logic [1:0]  errorA,     errorB;
  logic [2:0]  countA,     countB;
  logic        idleA,      idleB;

  logic        sel0;
  logic        mCmdReady, mRspValid, mReqValid, mRespReady, mIdle;
  logic [31:0] mRspData;
  logic [1:0]  mRspStatus, mError;
  logic [40:0] mReq;
  logic [2:0]  mCount;

  int          nEval = 0;
  int          nFail = 0;
  exp_t        sbQ[$];
  logic [31:0] dmMem [128];
  bit          dmHold;
  bit          pend;
  logic [31:0] pendData;
  logic [1:0]  pendCode;
  logic [1:0]  dmRespCode;
  int          reqFireCnt = 0;
  int          respFireCnt = 0;
  int          rspFireCnt = 0;

  dmi_req_engine dutA (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValid), .cmd_addr_i(cmdAddr), .cmd_data_i(cmdData), .cmd_op_i(cmdOp),
    .cmd_ready_o(cmdReadyA), .rsp_valid_o(rspValidA), .rsp_ready_i(rspReady),
    .rsp_data_o(rspDataA), .rsp_status_o(rspStatusA),
    .dmi_req_o(reqA), .dmi_req_valid_o(reqValidA), .dmi_req_ready_i(dmReqReady),
    .dmi_resp_i(dmResp), .dmi_resp_valid_i(dmRespValid), .dmi_resp_ready_o(respReadyA),
    .dmi_reset_i(dmiReset), .dmi_hard_reset_i(dmiHardReset),
    .error_o(errorA), .count_o(countA), .idle_o(idleA)
  );

  dmi_req_engine #(.StallOnFull(0)) dutB (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValid), .cmd_addr_i(cmdAddr), .cmd_data_i(cmdData), .cmd_op_i(cmdOp),
    .cmd_ready_o(cmdReadyB), .rsp_valid_o(rspValidB), .rsp_ready_i(rspReady),
    .rsp_data_o(rspDataB), .rsp_status_o(rspStatusB),
    .dmi_req_o(reqB), .dmi_req_valid_o(reqValidB), .dmi_req_ready_i(dmReqReady),
    .dmi_resp_i(dmResp), .dmi_resp_valid_i(dmRespValid), .dmi_resp_ready_o(respReadyB),
    .dmi_reset_i(dmiReset), .dmi_hard_reset_i(dmiHardReset),
    .error_o(errorB), .count_o(countB), .idle_o(idleB)
  );

  assign mCmdReady  = sel0 ? cmdReadyB  : cmdReadyA;
  assign mRspValid  = sel0 ? rspValidB  : rspValidA;
  assign mRspData   = sel0 ? rspDataB   : rspDataA;
  assign mRspStatus = sel0 ? rspStatusB : rspStatusA;
  assign mReq       = sel0 ? reqB       : reqA;
  assign mReqValid  = sel0 ? reqValidB  : reqValidA;
  assign mRespReady = sel0 ? respReadyB : respReadyA;
  assign mError     = sel0 ? errorB     : errorA;
  assign mCount     = sel0 ? countB     : countA;
  assign mIdle      = sel0 ? idleB      : idleA;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nEval++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes due at the coming edge, run the DM model, advance to the next negedge.
  task automatic cycle();
    logic [6:0]  a;
    exp_t        e;
    bit          reqFire;
    bit          rspFire;
    reqFire = (mReqValid === 1'b1) && dmReqReady;
    rspFire = (mRspValid === 1'b1) && rspReady;
    if (dmRespValid && (mRespReady === 1'b1)) begin
      pend = 1'b0;
      respFireCnt++;
    end
    if (reqFire) begin
      reqFireCnt++;
      a = mReq[40:34];
      if (mReq[33:32] == 2'd2) begin
        dmMem[a] = mReq[31:0];
        pendData = 32'hBAD0BAD0;
      end else begin
        pendData = dmMem[a];
      end
      pendCode = dmRespCode;
      pend     = 1'b1;
    end
    if (rspFire) begin
      rspFireCnt++;
      checkOutput("rsp_expected", 64'(sbQ.size() != 0), 64'd1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput("rsp_data", 64'(mRspData), 64'(e.data));
        checkOutput("rsp_status", 64'(mRspStatus), 64'(e.status));
      end
    end
    @(posedge clk);
    @(negedge clk);
    dmRespValid = pend && !dmHold;
    dmResp      = {pendData, pendCode};
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                               input bit pushExp, input logic [31:0] expData, input logic [1:0] expStatus);
    bit fired;
    fired    = 1'b0;
    cmdOp    = op;
    cmdAddr  = addr;
    cmdData  = data;
    cmdValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mCmdReady === 1'b1) begin
        if (pushExp) sbQ.push_back('{data: expData, status: expStatus});
        cycle();
        fired = 1'b1;
        break;
      end
      cycle();
    end
    cmdValid = 1'b0;
    checkOutput("cmd_accept", 64'(fired), 64'd1);
  endtask

  task automatic runUntilIdle(input int maxCycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      cycle();
      if ((mIdle === 1'b1) && (sbQ.size() == 0)) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("idle_reached", 64'(done), 64'd1);
  endtask

  task automatic resetDut();
    pend        = 1'b0;
    dmRespValid = 1'b0;
    rstN        = 1'b0;
    cycle();
    cycle();
    sbQ.delete();
    rstN = 1'b1;
  endtask

  // Directed test sequence.
  initial begin
    int          reqMark;
    int          respMark;
    int          rspMark;
    logic [40:0] expReq;

    rstN = 1'b0; cmdValid = 1'b0; cmdAddr = '0; cmdData = '0; cmdOp = '0;
    rspReady = 1'b1; dmReqReady = 1'b1; dmResp = '0; dmRespValid = 1'b0;
    dmiReset = 1'b0; dmiHardReset = 1'b0; sel0 = 1'b0; dmHold = 1'b0;
    pend = 1'b0; pendData = '0; pendCode = '0; dmRespCode = 2'd0;
    for (int i = 0; i < 128; i++) dmMem[i] = 32'h0;
    dmMem[7'h11] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) dmMem[7'h20 + i] = 32'hA0000020 + i;
    dmMem[7'h30] = 32'h55AA0030;

    // Reset values.
    resetDut();
    checkOutput("rst_cmd_ready", 64'(mCmdReady), 64'd1);
    checkOutput("rst_rsp_valid", 64'(mRspValid), 64'd0);
    checkOutput("rst_req_valid", 64'(mReqValid), 64'd0);
    checkOutput("rst_count", 64'(mCount), 64'd0);
    checkOutput("rst_error", 64'(mError), 64'd0);
    checkOutput("rst_idle", 64'(mIdle), 64'd1);
    checkOutput("rst_req", 64'(mReq), 64'd0);

    // Read with minimum latency.
    applyStimulus(2'd1, 7'h11, 32'h0, 1'b1, 32'hDEADBEEF, 2'd0);
    cycle();
    checkOutput("rd_req_valid", 64'(mReqValid), 64'd1);
    checkOutput("rd_req_addr", 64'(mReq[40:34]), 64'h11);
    checkOutput("rd_req_op", 64'(mReq[33:32]), 64'd1);
    cycle();
    checkOutput("rd_rsp_not_early", 64'(mRspValid), 64'd0);
    cycle();
    checkOutput("rd_rsp_latency4", 64'(mRspValid), 64'd1);
    runUntilIdle(10);

    // Write with DM holding off ready: request must stay valid and stable.
    dmReqReady = 1'b0;
    expReq = {7'h05, 2'd2, 32'h12345678};
    applyStimulus(2'd2, 7'h05, 32'h12345678, 1'b1, 32'h12345678, 2'd0);
    for (int i = 0; i < 10; i++) begin
      if (mReqValid === 1'b1) break;
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("wr_req_held_valid", 64'(mReqValid), 64'd1);
      checkOutput("wr_req_held_value", 64'(mReq), 64'(expReq));
      cycle();
    end
    dmReqReady = 1'b1;
    runUntilIdle(10);
    applyStimulus(2'd1, 7'h05, 32'h0, 1'b1, 32'h12345678, 2'd0);
    runUntilIdle(10);

    // Nop and reserved ops answer locally without touching the DM.
    reqMark = reqFireCnt;
    applyStimulus(2'd0, 7'h01, 32'hFFFFFFFF, 1'b1, 32'h0, 2'd0);
    applyStimulus(2'd3, 7'h02, 32'hFFFFFFFF, 1'b1, 32'h0, 2'd0);
    runUntilIdle(10);
    checkOutput("nop_no_dm_req", 64'(reqFireCnt), 64'(reqMark));

    // Fill with the response side stalled; count holds on simultaneous push and pop.
    rspReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'd1, 7'(7'h20 + i), 32'h0, 1'b1, 32'hA0000020 + i, 2'd0);
      checkOutput("fill_count", 64'(mCount), (i == 0) ? 64'd1 : 64'(i));
    end
    cmdOp = 2'd1; cmdAddr = 7'h25; cmdData = '0; cmdValid = 1'b1;
    checkOutput("full_cmd_ready", 64'(mCmdReady), 64'd0);
    checkOutput("full_count", 64'(mCount), 64'd4);
    checkOutput("full_rsp_valid", 64'(mRspValid), 64'd1);
    checkOutput("full_rsp_data", 64'(mRspData), 64'hA0000020);
    cycle();
    cycle();
    checkOutput("full_cmd_ready_hold", 64'(mCmdReady), 64'd0);
    checkOutput("rsp_stable_data", 64'(mRspData), 64'hA0000020);
    checkOutput("rsp_stable_status", 64'(mRspStatus), 64'd0);
    cmdValid = 1'b0;
    rspReady = 1'b1;
    runUntilIdle(60);

    // Overflow on the dropping instance: error 3, queued writes skipped with status 3.
    sel0 = 1'b1;
    resetDut();
    rspReady = 1'b0;
    applyStimulus(2'd1, 7'h30, 32'h0, 1'b1, 32'h55AA0030, 2'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'd2, 7'(7'h31 + i), 32'h11110000 + i, 1'b1, 32'h0, 2'd3);
    end
    applyStimulus(2'd2, 7'h3F, 32'h99999999, 1'b0, 32'h0, 2'd0);
    checkOutput("ovf_error", 64'(mError), 64'd3);
    checkOutput("ovf_count", 64'(mCount), 64'd4);
    checkOutput("ovf_cmd_ready", 64'(mCmdReady), 64'd1);
    reqMark = reqFireCnt;
    rspReady = 1'b1;
    runUntilIdle(40);
    checkOutput("ovf_no_dm_req", 64'(reqFireCnt), 64'(reqMark));
    dmiReset = 1'b1;
    cycle();
    dmiReset = 1'b0;
    checkOutput("ovf_error_cleared", 64'(mError), 64'd0);

    // DM failure: first error sticks, later commands skip, clear beats a new error.
    sel0 = 1'b0;
    resetDut();
    dmRespCode = 2'd2;
    applyStimulus(2'd2, 7'h08, 32'hCAFE0001, 1'b1, 32'hCAFE0001, 2'd2);
    runUntilIdle(10);
    checkOutput("dmerr_error2", 64'(mError), 64'd2);
    dmRespCode = 2'd3;
    reqMark = reqFireCnt;
    applyStimulus(2'd1, 7'h08, 32'h0, 1'b1, 32'h0, 2'd2);
    runUntilIdle(10);
    checkOutput("dmerr_sticky", 64'(mError), 64'd2);
    checkOutput("dmerr_skip_no_req", 64'(reqFireCnt), 64'(reqMark));
    dmiReset = 1'b1;
    cycle();
    checkOutput("dmerr_cleared", 64'(mError), 64'd0);
    applyStimulus(2'd2, 7'h09, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 2'd3);
    runUntilIdle(10);
    checkOutput("dmerr_clear_wins", 64'(mError), 64'd0);
    dmiReset = 1'b0;
    dmRespCode = 2'd0;

    // Hard reset while waiting on the DM with three commands queued.
    dmHold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'd2, 7'(7'h40 + i), 32'h40400000 + i, 1'b0, 32'h0, 2'd0);
    end
    checkOutput("hr_count_before", 64'(mCount), 64'd3);
    checkOutput("hr_in_wait", 64'(mRespReady), 64'd1);
    respMark = respFireCnt;
    rspMark  = rspFireCnt;
    dmiHardReset = 1'b1;
    cycle();
    dmiHardReset = 1'b0;
    checkOutput("hr_count_flushed", 64'(mCount), 64'd0);
    dmHold = 1'b0;
    cycle();
    cycle();
    runUntilIdle(10);
    checkOutput("hr_dm_handshake", 64'(respFireCnt), 64'(respMark + 1));
    checkOutput("hr_no_rsp", 64'(rspFireCnt), 64'(rspMark));
    checkOutput("hr_idle", 64'(mIdle), 64'd1);

    // Reset while a request is outstanding.
    dmReqReady = 1'b0;
    applyStimulus(2'd1, 7'h11, 32'h0, 1'b1, 32'hDEADBEEF, 2'd0);
    for (int i = 0; i < 10; i++) begin
      if (mReqValid === 1'b1) break;
      cycle();
    end
    checkOutput("mid_req_valid", 64'(mReqValid), 64'd1);
    pend = 1'b0;
    rstN = 1'b0;
    cycle();
    checkOutput("mid_rst_req_valid", 64'(mReqValid), 64'd0);
    checkOutput("mid_rst_rsp_valid", 64'(mRspValid), 64'd0);
    checkOutput("mid_rst_resp_ready", 64'(mRespReady), 64'd0);
    checkOutput("mid_rst_req", 64'(mReq), 64'd0);
    checkOutput("mid_rst_count", 64'(mCount), 64'd0);
    checkOutput("mid_rst_error", 64'(mError), 64'd0);
    checkOutput("mid_rst_idle", 64'(mIdle), 64'd1);
    checkOutput("mid_rst_cmd_ready", 64'(mCmdReady), 64'd1);
    sbQ.delete();
    rstN = 1'b1;
    dmReqReady = 1'b1;
    cycle();
    checkOutput("sb_empty_end", 64'(sbQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nEval, nFail);
    $finish;
  end

endmodule

// File: doc/dmi_req_engine.md
DMI_REQ_ENGINE -- requirements
Module: dmi_req_engine

Interface
REQ-001 SHALL have parameter AddrWidth, default 7, DMI address width.
REQ-002 SHALL have parameter Depth, default 4, command FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter StallOnFull, default 1.
- 1: cmd_ready_o low while full.
- 0: cmd_ready_o always high; a command offered while full is dropped and flagged busy.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-006 SHALL have command-side inputs:
- cmd_valid_i, 1.
- cmd_addr_i, AddrWidth.
- cmd_data_i, 32.
- cmd_op_i, 2: 0 nop, 1 read, 2 write, 3 reserved (treated as nop).
REQ-007 SHALL have port cmd_ready_o, output, 1, command accept.
REQ-008 SHALL have response-side ports:
- rsp_valid_o, output, 1.
- rsp_ready_i, input, 1.
- rsp_data_o, output, 32.
- rsp_status_o, output, 2: 0 ok, 2 failed, 3 busy.
REQ-009 SHALL have DM-side request ports:
- dmi_req_o, output, AddrWidth+34, packed {addr, op, data}.
- dmi_req_valid_o, output, 1.
- dmi_req_ready_i, input, 1.
REQ-010 SHALL have DM-side response ports:
- dmi_resp_i, input, 34, {data[33:2], resp[1:0]}.
- dmi_resp_valid_i, input, 1.
- dmi_resp_ready_o, output, 1.
REQ-011 SHALL have control/status ports:
- dmi_reset_i, input, 1, clears sticky error.
- dmi_hard_reset_i, input, 1, flush.
- error_o, output, 2, sticky error.
- count_o, output, $clog2(Depth)+1, FIFO occupancy.
- idle_o, output, 1.

Function
REQ-012 SHALL accept a command when cmd_valid_i && cmd_ready_o; the entry is visible at the FIFO head the next cycle.
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, RSP.
- IDLE: if FIFO non-empty, pop head to the txn register, then go to REQ. If the op is nop/reserved, or error_o != 0, go to RSP instead, without any DM access.
- REQ: assert dmi_req_valid_o; go to WAIT on dmi_req_ready_i.
- WAIT: assert dmi_resp_ready_o; on dmi_resp_valid_i, capture data and status, go to RSP.
- RSP: assert rsp_valid_o; go to IDLE on rsp_ready_i.
REQ-014 SHALL hold dmi_req_o stable, and keep dmi_req_valid_o high, from assertion until dmi_req_ready_i.
REQ-015 SHALL hold rsp_data_o and rsp_status_o stable while rsp_valid_o && !rsp_ready_i.
REQ-016 SHALL respond to skipped commands as follows:
- nop: rsp_data_o = 0, rsp_status_o = 0.
- Command skipped due to sticky error: rsp_data_o = 0, rsp_status_o = error_o.
REQ-017 SHALL set rsp_data_o:
- read: dmi_resp data.
- write: the written data.
REQ-018 SHALL set rsp_status_o from dmi_resp resp; resp values 2 and 3 set error_o to that value, but only if error_o == 0 (first error sticky).
REQ-019 SHALL, when StallOnFull = 0, set error_o to 3 (if currently 0) on a command offered while full, and drop that command with no response.
REQ-020 SHALL clear error_o to 0 the cycle after dmi_reset_i; a clear coincident with a new error SHALL win.
REQ-021 SHALL handle dmi_hard_reset_i as follows:
- Empty the FIFO the next cycle.
- If in RSP, discard the response and go to IDLE.
- If in REQ or WAIT, complete the DM handshake and then discard the response; no rsp_valid_o is produced for it.
REQ-022 SHALL, on a simultaneous push and pop, keep count_o unchanged; a push when full with StallOnFull = 0 SHALL not corrupt FIFO contents.
REQ-023 SHALL drive idle_o = (state == IDLE) && count_o == 0.
REQ-024 SHALL achieve minimum latency 4 cycles from command accept to rsp_valid_o, with dmi_req_ready_i tied high and the DM responding one cycle after the request.

Reset
REQ-025 SHALL, on rst_ni low at a clk_i edge, put the block in reset state:
- state IDLE, FIFO empty, count_o 0, error_o 0, txn register 0.
- All valid outputs 0; idle_o 1.
- cmd_ready_o 1 from the first cycle after reset.
REQ-026 SHALL, on reset mid-transaction, abandon it immediately; dmi_req_valid_o is permitted to drop without ready.

Structure
REQ-027 SHALL take op and response-status encodings from the shared dm package; no local redefinition.
REQ-028 SHALL implement the command FIFO as one sub-module, dmi_req_fifo, parametrised by width and Depth; FSM and error logic SHALL stay in the top.

Verification
REQ-029 Read: cmd op 1, addr 0x11; DM returns {0xDEADBEEF, 0} one cycle after handshake -> rsp_valid_o exactly 4 cycles after accept, data 0xDEADBEEF, status 0, dmi_req_o op 1 addr 0x11.
REQ-030 Full, Depth 4, StallOnFull 1, rsp_ready_i 0 -> the engine holds the first command in RSP and 4 more fill the FIFO, so the 6th command sees cmd_ready_o 0, count_o 4. Releasing rsp_ready_i -> 5 responses in order.
REQ-031 Overflow, StallOnFull 0 -> extra command dropped, error_o 3; subsequent queued write skipped with status 3, no dmi_req_valid_o; dmi_reset_i -> error_o 0 next cycle.
REQ-032 DM failure: resp 2 on a write -> status 2, error_o 2; a later resp 3 leaves error_o 2; dmi_reset_i coincident with a new error -> error_o 0.
REQ-033 Hard reset: pulse in WAIT with 3 queued -> count_o 0 next cycle, DM handshake completes, no rsp_valid_o, idle_o 1 afterwards.
REQ-034 Reset: rst_ni low while dmi_req_valid_o is high -> all outputs at reset values the next cycle.
